// File: rtl/sprite_motion_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_motion_ctrl_pkg
//  Description : Constants shared by the sprite motion controller and merge stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_motion_ctrl_pkg;

    localparam int BG_SIZE_X   = 1000;
    localparam int BG_SIZE_Y   = 1000;
    localparam int SPRITE_SIZE = 16;

    localparam int POS_W  = 10;
    localparam int CAND_W = 12;
    localparam int COL_W  = 4;

    localparam logic [COL_W-1:0] COL_NONE   = 4'b0000;
    localparam logic [COL_W-1:0] COL_RIGHT  = 4'b0001;
    localparam logic [COL_W-1:0] COL_LEFT   = 4'b0010;
    localparam logic [COL_W-1:0] COL_BOTTOM = 4'b0100;
    localparam logic [COL_W-1:0] COL_TOP    = 4'b1000;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SAMPLE  = 3'd1;
    localparam state_t ST_MOVE    = 3'd2;
    localparam state_t ST_CLAMP   = 3'd3;
    localparam state_t ST_PUBLISH = 3'd4;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_POS  = 2'd1,
        DIR_NEG  = 2'd2
    } dir_t;

    // Opposing requests cancel; a collision on the requested side blocks the axis.
    function automatic dir_t resolve_dir(input logic req_pos, input logic req_neg,
                                         input logic blk_pos, input logic blk_neg);
        dir_t d;
        d = DIR_NONE;
        if (req_pos && !req_neg && !blk_pos) begin
            d = DIR_POS;
        end else if (req_neg && !req_pos && !blk_neg) begin
            d = DIR_NEG;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_motion_ctrl_if
//  Description : Button/collision inputs and position outputs of the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_motion_ctrl_if;
    import sprite_motion_ctrl_pkg::*;

    logic             frame_tick;
    logic             btn_left;
    logic             btn_right;
    logic             btn_up;
    logic             btn_down;
    logic [COL_W-1:0] collision;
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             pos_valid;
    logic             overrun;

    modport master (
        output frame_tick, btn_left, btn_right, btn_up, btn_down, collision,
        input  pos_x, pos_y, pos_valid, overrun
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_up, btn_down, collision,
        output pos_x, pos_y, pos_valid, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sprite_motion_ctrl_axis_mover.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_motion_ctrl_axis_mover
//  Description : One axis: direction latch, acceleration, signed step, clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_ctrl_axis_mover
    import sprite_motion_ctrl_pkg::*;
#(
    parameter int INIT_POS     = 492,
    parameter int MAX_POS      = 984,
    parameter int MAX_SPEED    = 4,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en_i,
    input  logic             move_en_i,
    input  logic             clamp_en_i,
    input  logic             publish_en_i,
    input  logic             req_pos_i,
    input  logic             req_neg_i,
    input  logic             blk_pos_i,
    input  logic             blk_neg_i,
    output logic [POS_W-1:0] pos_o
);

    localparam int SPEED_W = $clog2(MAX_SPEED + 1);
    localparam int CNT_W   = $clog2(ACCEL_FRAMES + 1);

    localparam logic [SPEED_W-1:0]       C_SPEED_MIN = SPEED_W'(1);
    localparam logic [SPEED_W-1:0]       C_SPEED_MAX = SPEED_W'(MAX_SPEED);
    localparam logic [CNT_W-1:0]         C_ACCEL     = CNT_W'(ACCEL_FRAMES);
    localparam logic [POS_W-1:0]         C_INIT      = POS_W'(INIT_POS);
    localparam logic [POS_W-1:0]         C_MAX_POS   = POS_W'(MAX_POS);
    localparam logic signed [CAND_W-1:0] C_MAX_CAND  = CAND_W'(MAX_POS);

    dir_t                     dir_q;
    dir_t                     last_dir_q;
    logic [SPEED_W-1:0]       speed_q, speed_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [CAND_W-1:0] cand_q, cand_d;
    logic [POS_W-1:0]         clamp_q, clamp_d;
    logic [POS_W-1:0]         pos_q;
    logic                     clamp_hit;
    logic signed [CAND_W-1:0] pos_ext;
    logic signed [CAND_W-1:0] step;

    // Speed/counter update; the step taken this frame uses the updated speed.
    always_comb begin
        speed_d = C_SPEED_MIN;
        cnt_d   = '0;
        if (dir_q != DIR_NONE && dir_q == last_dir_q) begin
            if (cnt_q + CNT_W'(1) == C_ACCEL) begin
                speed_d = (speed_q >= C_SPEED_MAX) ? C_SPEED_MAX : speed_q + C_SPEED_MIN;
                cnt_d   = '0;
            end else begin
                speed_d = speed_q;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    assign pos_ext = signed'({{(CAND_W-POS_W){1'b0}}, pos_q});
    assign step    = signed'({{(CAND_W-SPEED_W){1'b0}}, speed_d});

    always_comb begin
        case (dir_q)
            DIR_POS: cand_d = pos_ext + step;
            DIR_NEG: cand_d = pos_ext - step;
            default: cand_d = pos_ext;
        endcase
    end

    always_comb begin
        clamp_hit = 1'b0;
        clamp_d   = cand_q[POS_W-1:0];
        if (cand_q[CAND_W-1]) begin
            clamp_hit = 1'b1;
            clamp_d   = '0;
        end else if (cand_q > C_MAX_CAND) begin
            clamp_hit = 1'b1;
            clamp_d   = C_MAX_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q      <= DIR_NONE;
            last_dir_q <= DIR_NONE;
            speed_q    <= C_SPEED_MIN;
            cnt_q      <= '0;
            cand_q     <= '0;
            clamp_q    <= C_INIT;
            pos_q      <= C_INIT;
        end else begin
            if (sample_en_i) begin
                dir_q <= resolve_dir(req_pos_i, req_neg_i, blk_pos_i, blk_neg_i);
            end
            if (move_en_i) begin
                speed_q    <= speed_d;
                cnt_q      <= cnt_d;
                last_dir_q <= dir_q;
                cand_q     <= cand_d;
            end
            if (clamp_en_i) begin
                clamp_q <= clamp_d;
                // Hitting the wall restarts acceleration from scratch.
                if (clamp_hit) begin
                    speed_q <= C_SPEED_MIN;
                    cnt_q   <= '0;
                end
            end
            if (publish_en_i) begin
                pos_q <= clamp_q;
            end
        end
    end

    assign pos_o = pos_q;

endmodule
`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_motion_ctrl
//  Description : Per-frame sprite position update with acceleration and clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_motion_ctrl
    import sprite_motion_ctrl_pkg::*;
#(
    parameter int INIT_X       = 492,
    parameter int INIT_Y       = 492,
    parameter int MAX_SPEED    = 4,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_motion_ctrl_if.slave  bus
);

    localparam int MAX_POS_X = BG_SIZE_X - SPRITE_SIZE;
    localparam int MAX_POS_Y = BG_SIZE_Y - SPRITE_SIZE;

    state_t state_q, state_d;
    logic   sample_en, move_en, clamp_en, publish_en;
    logic   pos_valid_q, overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.frame_tick) state_d = ST_SAMPLE;
            ST_SAMPLE:  state_d = ST_MOVE;
            ST_MOVE:    state_d = ST_CLAMP;
            ST_CLAMP:   state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sample_en  = (state_q == ST_SAMPLE);
        move_en    = (state_q == ST_MOVE);
        clamp_en   = (state_q == ST_CLAMP);
        publish_en = (state_q == ST_PUBLISH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pos_valid_q <= publish_en;
            overrun_q   <= overrun_q | (bus.frame_tick && state_q != ST_IDLE);
        end
    end

    sprite_motion_ctrl_axis_mover #(
        .INIT_POS     (INIT_X),
        .MAX_POS      (MAX_POS_X),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_axis_x (
        .clk          (clk),
        .reset        (reset),
        .sample_en_i  (sample_en),
        .move_en_i    (move_en),
        .clamp_en_i   (clamp_en),
        .publish_en_i (publish_en),
        .req_pos_i    (bus.btn_right),
        .req_neg_i    (bus.btn_left),
        .blk_pos_i    (|(bus.collision & COL_RIGHT)),
        .blk_neg_i    (|(bus.collision & COL_LEFT)),
        .pos_o        (bus.pos_x)
    );

    sprite_motion_ctrl_axis_mover #(
        .INIT_POS     (INIT_Y),
        .MAX_POS      (MAX_POS_Y),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_axis_y (
        .clk          (clk),
        .reset        (reset),
        .sample_en_i  (sample_en),
        .move_en_i    (move_en),
        .clamp_en_i   (clamp_en),
        .publish_en_i (publish_en),
        .req_pos_i    (bus.btn_down),
        .req_neg_i    (bus.btn_up),
        .blk_pos_i    (|(bus.collision & COL_BOTTOM)),
        .blk_neg_i    (|(bus.collision & COL_TOP)),
        .pos_o        (bus.pos_y)
    );

    assign bus.pos_valid = pos_valid_q;
    assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_motion_ctrl
//  Description : Self-checking bench: vector table, corner sequences, random frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_motion_ctrl;

    localparam int ACCEL  = 8;
    localparam int MAXS   = 4;
    localparam int LIMIT  = 984;
    localparam int INIT_P = 492;

    typedef struct {
        logic       l;
        logic       r;
        logic       u;
        logic       d;
        logic [3:0] col;
        int         ex;
        int         ey;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    // Reference state: position, length of the current uninterrupted run, last direction.
    int m_pos[2];
    int m_run[2];
    int m_last[2];

    sprite_motion_ctrl_if bus_if ();

    sprite_motion_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_axis(input int a, input int dir);
        int spd;
        int np;
        int cl;
        if (dir == 0 || dir != m_last[a]) m_run[a] = 0;
        else m_run[a] = m_run[a] + 1;
        m_last[a] = dir;
        spd = 1 + m_run[a] / ACCEL;
        if (spd > MAXS) spd = MAXS;
        np = m_pos[a] + dir * spd;
        cl = (np < 0) ? 0 : ((np > LIMIT) ? LIMIT : np);
        if (cl != np) m_run[a] = 0;
        m_pos[a] = cl;
    endtask

    task automatic model_frame(input logic l, input logic r, input logic u, input logic d,
                               input logic [3:0] col);
        int dx;
        int dy;
        dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        if ((dx == 1 && col == 4'b0001) || (dx == -1 && col == 4'b0010)) dx = 0;
        dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
        if ((dy == 1 && col == 4'b0100) || (dy == -1 && col == 4'b1000)) dy = 0;
        model_axis(0, dx);
        model_axis(1, dy);
    endtask

    task automatic model_reset();
        m_pos  = '{INIT_P, INIT_P};
        m_run  = '{0, 0};
        m_last = '{0, 0};
    endtask

    task automatic set_inputs(input logic l, input logic r, input logic u, input logic d,
                              input logic [3:0] col);
        bus_if.btn_left  = l;
        bus_if.btn_right = r;
        bus_if.btn_up    = u;
        bus_if.btn_down  = d;
        bus_if.collision = col;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus_if.frame_tick = 1'b0;
        set_inputs(0, 0, 0, 0, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_frame(input logic l, input logic r, input logic u, input logic d,
                            input logic [3:0] col);
        int k;
        bit seen;
        @(negedge clk);
        set_inputs(l, r, u, d, col);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (k == 3) chk("pos_hold", int'(bus_if.pos_x), m_pos[0]);
            if (bus_if.pos_valid) seen = 1'b1;
        end
        chk("latency", seen ? k : -1, 4);
        model_frame(l, r, u, d, col);
        chk("pos_x", int'(bus_if.pos_x), m_pos[0]);
        chk("pos_y", int'(bus_if.pos_y), m_pos[1]);
        @(negedge clk);
        chk("valid_width", int'(bus_if.pos_valid), 0);
    endtask

    task automatic count_valid(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus_if.pos_valid) pulses++;
        end
    endtask

    vec_t tbl[21];

    initial begin
        int pulses;
        int run_left;
        int s;
        logic [3:0] pat;
        logic [3:0] col;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.frame_tick = 1'b0;
        set_inputs(0, 0, 0, 0, 4'b0000);
        model_reset();

        tbl[0]  = '{0, 0, 0, 0, 4'b0000, 492, 492};
        tbl[1]  = '{0, 1, 0, 0, 4'b0000, 493, 492};
        tbl[2]  = '{0, 1, 0, 0, 4'b0000, 494, 492};
        tbl[3]  = '{0, 1, 0, 0, 4'b0000, 495, 492};
        tbl[4]  = '{0, 1, 0, 0, 4'b0000, 496, 492};
        tbl[5]  = '{0, 1, 0, 0, 4'b0000, 497, 492};
        tbl[6]  = '{0, 1, 0, 0, 4'b0000, 498, 492};
        tbl[7]  = '{0, 1, 0, 0, 4'b0000, 499, 492};
        tbl[8]  = '{0, 1, 0, 0, 4'b0000, 500, 492};
        tbl[9]  = '{0, 1, 0, 0, 4'b0000, 502, 492};
        tbl[10] = '{0, 1, 0, 0, 4'b0000, 504, 492};
        tbl[11] = '{1, 1, 0, 0, 4'b0000, 504, 492};
        tbl[12] = '{0, 1, 0, 0, 4'b0000, 505, 492};
        tbl[13] = '{0, 1, 0, 0, 4'b0001, 505, 492};
        tbl[14] = '{1, 0, 0, 0, 4'b0010, 505, 492};
        tbl[15] = '{0, 0, 0, 1, 4'b0000, 505, 493};
        tbl[16] = '{0, 0, 1, 0, 4'b1000, 505, 493};
        tbl[17] = '{0, 0, 0, 1, 4'b0100, 505, 493};
        tbl[18] = '{0, 0, 0, 1, 4'b0010, 505, 494};
        tbl[19] = '{0, 0, 1, 1, 4'b0000, 505, 494};
        tbl[20] = '{1, 0, 1, 0, 4'b0000, 504, 493};

        do_reset();
        @(negedge clk);
        chk("reset_pos_x", int'(bus_if.pos_x), 492);
        chk("reset_pos_y", int'(bus_if.pos_y), 492);
        chk("reset_valid", int'(bus_if.pos_valid), 0);
        chk("reset_overrun", int'(bus_if.overrun), 0);

        for (int i = 0; i < 21; i++) begin
            do_frame(tbl[i].l, tbl[i].r, tbl[i].u, tbl[i].d, tbl[i].col);
            chk($sformatf("tbl%0d_x", i), int'(bus_if.pos_x), tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), int'(bus_if.pos_y), tbl[i].ey);
        end

        // Right edge: offset by 3, then accelerate so the last full-speed step lands on 983.
        do_reset();
        for (int i = 0; i < 3; i++) do_frame(0, 1, 0, 0, 4'b0000);
        do_frame(0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 134; i++) do_frame(0, 1, 0, 0, 4'b0000);
        chk("edge_r_983", int'(bus_if.pos_x), 983);
        do_frame(0, 1, 0, 0, 4'b0000);
        chk("edge_r_clamp", int'(bus_if.pos_x), 984);
        do_frame(0, 1, 0, 0, 4'b0001);
        chk("edge_r_blocked", int'(bus_if.pos_x), 984);
        do_frame(1, 0, 0, 0, 4'b0000);
        chk("edge_r_back", int'(bus_if.pos_x), 983);

        // Top-left corner: both axes reach 1 at full speed, then clamp to 0.
        do_reset();
        for (int i = 0; i < 3; i++) do_frame(1, 0, 1, 0, 4'b0000);
        do_frame(0, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 134; i++) do_frame(1, 0, 1, 0, 4'b0000);
        chk("corner_x1", int'(bus_if.pos_x), 1);
        chk("corner_y1", int'(bus_if.pos_y), 1);
        do_frame(1, 0, 1, 0, 4'b0000);
        chk("corner_x0", int'(bus_if.pos_x), 0);
        chk("corner_y0", int'(bus_if.pos_y), 0);
        do_frame(1, 0, 0, 0, 4'b0010);
        chk("corner_blk_x", int'(bus_if.pos_x), 0);

        // Random walk from the corner, held patterns so acceleration develops.
        run_left = 0;
        pat = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            if (run_left == 0) begin
                pat = 4'($urandom_range(0, 15));
                run_left = $urandom_range(1, 30);
            end
            run_left--;
            s = $urandom_range(0, 7);
            col = (s < 4) ? 4'(1 << s) : 4'b0000;
            do_frame(pat[0], pat[1], pat[2], pat[3], col);
        end

        // Second tick arrives while the first frame is still in flight.
        do_reset();
        @(negedge clk);
        set_inputs(0, 1, 0, 0, 4'b0000);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        @(negedge clk);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        chk("overrun_set", int'(bus_if.overrun), 1);
        count_valid(3, pulses);
        chk("overrun_frame_pulse", pulses, 1);
        model_frame(0, 1, 0, 0, 4'b0000);
        chk("overrun_pos_x", int'(bus_if.pos_x), m_pos[0]);
        count_valid(8, pulses);
        chk("overrun_ignored", pulses, 0);
        chk("overrun_sticky", int'(bus_if.overrun), 1);
        do_frame(0, 1, 0, 0, 4'b0000);
        chk("overrun_still", int'(bus_if.overrun), 1);

        // Reset while the FSM is in MOVE.
        @(negedge clk);
        set_inputs(0, 1, 0, 0, 4'b0000);
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        count_valid(8, pulses);
        chk("midreset_no_valid", pulses, 0);
        chk("midreset_x", int'(bus_if.pos_x), 492);
        chk("midreset_y", int'(bus_if.pos_y), 492);
        chk("midreset_overrun", int'(bus_if.overrun), 0);

        // Reset and frame_tick together: reset wins.
        @(negedge clk);
        reset = 1'b1;
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_if.frame_tick = 1'b0;
        count_valid(8, pulses);
        chk("rst_tick_no_valid", pulses, 0);
        chk("rst_tick_x", int'(bus_if.pos_x), 492);

        do_frame(0, 1, 0, 1, 4'b0000);
        chk("final_x", int'(bus_if.pos_x), 493);
        chk("final_y", int'(bus_if.pos_y), 493);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
